// File: rtl/toggle_hs_pkg.sv
// Shared types and constants for the toggle-handshake pulse crossing.
package toggle_hs_pkg;

  typedef enum logic {ST_IDLE, ST_WAIT} t_tx_state;

  localparam int unsigned C_MIN_STAGES = 2;

endpackage

// File: rtl/ack_synchronizer.sv
// Brings the remote acknowledge level into the local clock domain and
// flags each change of the synchronized level for one cycle.
module ack_synchronizer
  import toggle_hs_pkg::*;
#(
  parameter int unsigned G_STAGES = C_MIN_STAGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_edge
);

  logic [G_STAGES-1:0] sync_q;
  logic                last_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[G_STAGES-2:0], i_async};
      last_q <= sync_q[G_STAGES-1];
    end
  end

  assign o_level = sync_q[G_STAGES-1];
  assign o_edge  = sync_q[G_STAGES-1] ^ last_q;

endmodule

// File: rtl/toggle_handshake_tx.sv
// Source side of the toggle pulse crossing: queues event pulses and issues
// them one at a time as request toggles, each held until acknowledged.
module toggle_handshake_tx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned G_STAGES = 2,
  parameter int unsigned G_CNT_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pulse,
  input  logic               i_ack_toggle,
  output logic               o_req_toggle,
  output logic               o_done,
  output logic               o_overflow,
  output logic               o_protocol_err,
  output logic [G_CNT_W-1:0] o_pending,
  output logic               o_busy
);

  localparam logic [G_CNT_W-1:0] C_CNT_MAX = '1;

  if (G_STAGES < C_MIN_STAGES) begin : g_bad_stages
    $error("toggle_handshake_tx: G_STAGES must be at least %0d", C_MIN_STAGES);
  end

  t_tx_state          state_q;
  logic               req_q;
  logic               done_q;
  logic               ovf_q;
  logic               err_q;
  logic               busy_q;
  logic [G_CNT_W-1:0] pend_q;
  logic [G_CNT_W-1:0] pend_d;
  logic               busy_d;
  logic               ack_level;
  logic               ack_edge;
  logic               dec_c;
  logic               issue_c;
  logic               ovf_c;

  ack_synchronizer #(
    .G_STAGES (G_STAGES)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_ack_toggle),
    .o_level (ack_level),
    .o_edge  (ack_edge)
  );

  // Counter next value; an ack edge seen while idle blocks issue for that cycle.
  always_comb begin
    dec_c   = (state_q == ST_WAIT) && (ack_level == req_q);
    issue_c = (state_q == ST_IDLE) && !ack_edge && (pend_q != '0);
    ovf_c   = i_pulse && !dec_c && (pend_q == C_CNT_MAX);
    pend_d  = pend_q;
    if (i_pulse && !dec_c && !ovf_c) begin
      pend_d = pend_q + G_CNT_W'(1);
    end else if (dec_c && !i_pulse) begin
      pend_d = pend_q - G_CNT_W'(1);
    end
    busy_d  = issue_c || ((state_q == ST_WAIT) && !dec_c) || (pend_d != '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= ovf_c;
      pend_q <= pend_d;
      busy_q <= busy_d;
      case (state_q)
        ST_IDLE: begin
          if (ack_edge) begin
            err_q <= 1'b1;
          end else if (issue_c) begin
            req_q   <= ~req_q;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dec_c) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_req_toggle   = req_q;
  assign o_done         = done_q;
  assign o_overflow     = ovf_q;
  assign o_protocol_err = err_q;
  assign o_pending      = pend_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_toggle_handshake_tx.sv
// Self-checking bench for toggle_handshake_tx: directed table, corner-case
// sequences and randomized traffic against an event-level reference model.
module tb_toggle_handshake_tx;

  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse;
  logic       ack_drv;
  logic       req, done, ovf, err, busy;
  logic [3:0] pend;

  logic       s_pulse;
  logic       s_ack;
  logic       s_req, s_done, s_ovf, s_err, s_busy;
  logic [1:0] s_pend;

  always #5 clk = ~clk;

  toggle_handshake_tx #(.G_STAGES(G), .G_CNT_W(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pulse        (pulse),
    .i_ack_toggle   (ack_drv),
    .o_req_toggle   (req),
    .o_done         (done),
    .o_overflow     (ovf),
    .o_protocol_err (err),
    .o_pending      (pend),
    .o_busy         (busy)
  );

  toggle_handshake_tx #(.G_STAGES(G), .G_CNT_W(2)) dut_s (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pulse        (s_pulse),
    .i_ack_toggle   (s_ack),
    .o_req_toggle   (s_req),
    .o_done         (s_done),
    .o_overflow     (s_ovf),
    .o_protocol_err (s_err),
    .o_pending      (s_pend),
    .o_busy         (s_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Event-level model: counts, one request in flight, done G edges after the ack edge.
  int m_pend, m_max, m_done_at, cyc;
  bit m_req, m_inflight, e_done, e_ovf, e_busy;
  int rem_cnt, rem_fix;
  bit rem_en, rem_rand;
  int flips, dones, peak;
  bit prev_req;

  task automatic model_reset();
    m_pend = 0; m_req = 1'b0; m_inflight = 1'b0; m_done_at = -1;
    rem_cnt = -1; ack_drv = 1'b0;
    flips = 0; dones = 0; peak = 0; prev_req = 1'b0;
  endtask

  task automatic model_edge(input bit p);
    bit dec;
    int pend_before;
    bit fl_before;
    dec = m_inflight && (cyc == m_done_at);
    pend_before = m_pend;
    fl_before = m_inflight;
    e_ovf = 1'b0;
    if (p && !dec) begin
      if (m_pend == m_max) e_ovf = 1'b1;
      else m_pend++;
    end else if (dec && !p) begin
      m_pend--;
    end
    e_done = dec;
    if (dec) m_inflight = 1'b0;
    else if (!fl_before && pend_before != 0) begin
      m_req = ~m_req;
      m_inflight = 1'b1;
    end
    e_busy = m_inflight || (m_pend != 0);
  endtask

  // Remote end: echoes each request after a delay; done lands G edges after the next edge.
  task automatic remote_step();
    if (!rem_en) return;
    if (rem_cnt < 0 && m_req != ack_drv)
      rem_cnt = rem_rand ? int'($urandom_range(0, 4)) : rem_fix;
    if (rem_cnt == 0) begin
      ack_drv = m_req;
      m_done_at = cyc + 1 + G;
      rem_cnt = -1;
    end else if (rem_cnt > 0) begin
      rem_cnt--;
    end
  endtask

  task automatic run_cycle(input bit p);
    pulse = p;
    @(posedge clk);
    cyc++;
    model_edge(p);
    #1;
    chk("req", int'(req), int'(m_req));
    chk("pending", int'(pend), m_pend);
    chk("done", int'(done), int'(e_done));
    chk("overflow", int'(ovf), int'(e_ovf));
    chk("busy", int'(busy), int'(e_busy));
    chk("protocol_err", int'(err), 0);
    if (req != prev_req) flips++;
    prev_req = req;
    if (done) dones++;
    if (int'(pend) > peak) peak = int'(pend);
    remote_step();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (!(m_pend == 0 && !m_inflight && rem_cnt < 0) && n < bound) begin
      run_cycle(1'b0);
      n++;
    end
    if (n >= bound) begin
      n_chk++;
      $display("FAIL drain_timeout: model still busy after %0d cycles", bound);
    end
    repeat (2) run_cycle(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pulse = 1'b0; s_pulse = 1'b0; s_ack = 1'b0; ack_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic       pulse, ack, req, done, busy, err;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int sat_ovf;
    bit found;
    // Single event with ack looped back, then a spurious ack toggle while idle.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

    m_max = 15; cyc = 0; rem_en = 1'b1; rem_rand = 1'b0; rem_fix = 1;
    do_reset();
    chk("rst_req", int'(req), 0);
    chk("rst_pending", int'(pend), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overflow", int'(ovf), 0);
    chk("rst_protocol_err", int'(err), 0);

    for (int i = 0; i < 12; i++) begin
      pulse = tbl[i].pulse;
      ack_drv = tbl[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_req", i), int'(req), int'(tbl[i].req));
      chk($sformatf("tbl%0d_pending", i), int'(pend), int'(tbl[i].pend));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_protocol_err", i), int'(err), int'(tbl[i].err));
      chk($sformatf("tbl%0d_overflow", i), int'(ovf), 0);
    end

    // Burst of 5 with the remote echoing every request.
    do_reset();
    repeat (5) run_cycle(1'b1);
    drain(200);
    chk("burst_peak", peak, 5);
    chk("burst_flips", flips, 5);
    chk("burst_dones", dones, 5);
    chk("burst_final_req", int'(req), 1);

    // Saturation on the 2-bit counter with ack withheld.
    sat_ovf = 0;
    for (int i = 0; i < 7; i++) begin
      s_pulse = (i < 5);
      @(posedge clk);
      #1;
      if (s_ovf) sat_ovf++;
    end
    s_pulse = 1'b0;
    chk("sat_overflow_count", sat_ovf, 2);
    chk("sat_pending", int'(s_pend), 3);
    chk("sat_req", int'(s_req), 1);
    chk("sat_busy", int'(s_busy), 1);

    // Pulse on the same edge as a done with two events pending.
    do_reset();
    rem_fix = 2;
    run_cycle(1'b1);
    run_cycle(1'b1);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_inflight && m_done_at == cyc + 1) begin
        found = 1'b1;
        break;
      end
      run_cycle(1'b0);
    end
    if (!found) begin
      n_chk++;
      $display("FAIL simul_timeout: done edge never reached");
    end else begin
      run_cycle(1'b1);
      chk("simul_pending", int'(pend), 2);
      chk("simul_done", int'(done), 1);
      chk("simul_overflow", int'(ovf), 0);
    end
    drain(200);

    // Reset while waiting with three events queued.
    do_reset();
    rem_en = 1'b0;
    repeat (3) run_cycle(1'b1);
    run_cycle(1'b0);
    chk("midrst_pre_pending", int'(pend), 3);
    chk("midrst_pre_req", int'(req), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_req", int'(req), 0);
    chk("midrst_pending", int'(pend), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_overflow", int'(ovf), 0);
    chk("midrst_protocol_err", int'(err), 0);
    model_reset();
    rem_en = 1'b1;
    rem_fix = 1;
    run_cycle(1'b1);
    drain(200);
    chk("midrst_after_dones", dones, 1);

    // Randomized traffic with random remote latency.
    do_reset();
    rem_rand = 1'b1;
    for (int i = 0; i < 400; i++) run_cycle($urandom_range(0, 99) < 35);
    drain(600);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/toggle_handshake_tx.md
# toggle_handshake_tx

Source-side transmitter for the toggle-based pulse crossing. Accepts single-cycle event pulses in its own clock domain, queues them in a saturating pending counter, and issues them one at a time as level toggles on a request line to a remote domain. Each toggle is held until the remote end returns a matching acknowledge toggle, so no event is lost when events arrive faster than the far domain can absorb them. The block sits in front of the destination's toggle receiver, which turns each request toggle back into a pulse and echoes it as the acknowledge.

## Interface
Parameters:
- G_STAGES, 2, flop stages on the asynchronous acknowledge input; minimum 2.
- G_CNT_W, 4, width of the pending-event counter; up to 2^G_CNT_W-1 events are queued.

Ports:
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_pulse  in  1  event request, one event per high cycle.
- i_ack_toggle  in  1  acknowledge level from the remote domain, asynchronous to i_clk.
- o_req_toggle  out  1  request level to the remote domain; flips once per issued event.
- o_done  out  1  one-cycle pulse when an issued event is acknowledged.
- o_overflow  out  1  one-cycle pulse when an event is dropped because the counter is full.
- o_protocol_err  out  1  one-cycle pulse on an acknowledge toggle with no outstanding request.
- o_pending  out  G_CNT_W  number of queued events not yet acknowledged, including any in flight.
- o_busy  out  1  high when state is ST_WAIT or o_pending != 0.

## Operation
- Reset (i_rst_n=0 at an edge): state ST_IDLE, o_req_toggle=0, o_pending=0, sync chain and ack edge flop=0, o_done=o_overflow=o_protocol_err=0, o_busy=0.
- Ack path: i_ack_toggle passes through G_STAGES flops. The last stage is registered once more, and ack_edge = last XOR registered.
- FSM:
  - ST_IDLE: if o_pending != 0, flip o_req_toggle and go to ST_WAIT. If ack_edge, pulse o_protocol_err and stay in ST_IDLE.
  - ST_WAIT: when the synchronized ack equals o_req_toggle, pulse o_done, decrement o_pending and return to ST_IDLE. Otherwise hold.
- Counter:
  - i_pulse with no decrement in the same cycle increments the counter.
  - Decrement with no i_pulse decrements it.
  - Both in the same cycle leave it unchanged.
  - i_pulse at the maximum value with no decrement drops the event, leaves the count at the maximum and pulses o_overflow.
- Issue order is FIFO by count. Events carry no payload.
- All outputs are registered.

## Timing
- i_pulse high at edge n with the block idle:
  - o_pending=1 after edge n.
  - o_req_toggle flips at edge n+1.
  - o_busy high after edge n.
- Acknowledge: a toggle of i_ack_toggle just before edge m completes the handshake as follows.
  - The synchronized ack matches after edge m+G_STAGES-1.
  - o_done is high after edge m+G_STAGES.
  - o_pending decrements at edge m+G_STAGES.
- Back-to-back events: one bubble cycle in ST_IDLE between o_done and the next request flip, so the minimum spacing between request flips is G_STAGES+2 cycles plus the remote round trip.
- Reset mid-handshake: o_req_toggle returns to 0 and queued events are discarded. The remote end must be reset in the same window, otherwise a spurious toggle is seen. An acknowledge arriving after reset raises o_protocol_err.

## Structure
- Package toggle_hs_pkg holds:
  - typedef enum logic {ST_IDLE, ST_WAIT} t_tx_state;
  - the minimum-stages constant C_MIN_STAGES=2, with an elaboration check G_STAGES >= C_MIN_STAGES.
- Sub-module ack_synchronizer: G_STAGES-flop chain plus edge flop, with outputs o_level and o_edge. The FSM and counter stay in the top level.

## Test plan
- Single event, G_STAGES=2:
  - i_pulse at edge 0 -> o_req_toggle=1 after edge 1.
  - Loop ack back 3 cycles later -> exactly one o_done, then o_pending=0, o_busy=0.
- Burst of 5 consecutive i_pulse with the remote echoing every request -> o_pending peaks at 5 and o_req_toggle flips 5 times, ending at 1. Exactly 5 o_done pulses, each flip waiting for the prior ack.
- Saturation, G_CNT_W=2, ack withheld: 5 pulses -> o_pending=3 and exactly 2 o_overflow pulses.
- Simultaneous i_pulse and o_done at o_pending=2 -> o_pending stays 2 and no overflow.
- Spurious ack toggle while ST_IDLE -> one o_protocol_err pulse G_STAGES+1 cycles later, with no change to o_req_toggle or o_pending.
- i_rst_n low for 1 cycle while in ST_WAIT with o_pending=3 -> all outputs at reset values after that edge. A new i_pulse afterwards is issued normally.
